// File: rtl/apes_stim_pkg.sv
// Shared types and defaults for the ASIC test-pulse generator and its response monitor.
package apes_stim_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam int CNT_W_DEF  = 16;
  localparam int LAT_W_DEF  = 8;
  localparam int WINDOW_DEF = 100;

  // Saturating increment of a w-bit value carried in 32 bits (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge detect flop.
module sync_edge_det (
  input  logic clk50,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/stim_response_monitor.sv
// Measures stim-to-hit latency of ASIC test pulses and keeps saturating hit/miss/spurious counters.
module stim_response_monitor
  import apes_stim_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LAT_W  = LAT_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             stim_en,
  input  logic             stim_in,
  input  logic             asic_hit,
  input  logic             clr,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] spur_cnt,
  output logic [LAT_W-1:0] last_lat,
  output logic             lat_valid,
  output logic             busy
);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(WINDOW - 1);

  state_e           state;
  logic [LAT_W-1:0] lat;
  logic             stim_d;
  logic             stim_edge;
  logic             hit_edge;

  // Reported latency includes the fixed synchronizer delay of this path.
  sync_edge_det u_hit_sync (
    .clk50 (clk50),
    .rst_n (rst_n),
    .sig   (asic_hit),
    .rise  (hit_edge)
  );

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) stim_d <= 1'b0;
    else        stim_d <= stim_in;
  end

  assign stim_edge = stim_in & ~stim_d & stim_en;
  assign busy      = (state == ARMED);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat       <= '0;
      pulse_cnt <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      spur_cnt  <= '0;
      last_lat  <= '0;
      lat_valid <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      lat       <= '0;
      pulse_cnt <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      spur_cnt  <= '0;
      last_lat  <= '0;
      lat_valid <= 1'b0;
    end else begin
      lat_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A hit coinciding with the opening edge belongs to no window.
          if (hit_edge) spur_cnt <= CNT_W'(sat_inc(32'(spur_cnt), CNT_W));
          if (stim_edge) begin
            pulse_cnt <= CNT_W'(sat_inc(32'(pulse_cnt), CNT_W));
            lat       <= '0;
            state     <= ARMED;
          end
        end
        ARMED: begin
          if (!stim_en) begin
            state <= IDLE;
          end else begin
            lat <= lat + 1'b1;
            if (hit_edge) begin
              hit_cnt   <= CNT_W'(sat_inc(32'(hit_cnt), CNT_W));
              last_lat  <= lat;
              lat_valid <= 1'b1;
              state     <= IDLE;
            end else if (stim_edge || (lat == LAT_LAST)) begin
              miss_cnt <= CNT_W'(sat_inc(32'(miss_cnt), CNT_W));
              state    <= IDLE;
            end
            // A new stim edge rescored above restarts the window.
            if (stim_edge) begin
              pulse_cnt <= CNT_W'(sat_inc(32'(pulse_cnt), CNT_W));
              lat       <= '0;
              state     <= ARMED;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
